kernel_fetch_seq: RTL and testbench
===================================

Name: kernel_fetch_seq

Overview:
- Upstream instruction-address sequencer for the filter GPU: generates the word-aligned byte PC that feeds the instruction-memory stage.
- Sequence is a one-time prologue of PROLOGUE_LEN instructions, then a kernel body of N_BODY instructions replayed once per pixel for NUM_PIXELS pixels, then halt.
- Replaces per-address modulo arithmetic with explicit counters, and tells the pixel address generator when each pixel begins.

Parameters:
- N_BODY, 18, number of instructions in the per-pixel kernel body (>=1).
- PROLOGUE_LEN, 4, number of one-time setup instructions at address 0 (>=1).
- NUM_PIXELS, 307200, pixels per frame (640*480).
- PIX_W, 19, width of pixel index; must satisfy 2**PIX_W >= NUM_PIXELS.

Ports:
- clk  in  1  system clock; all state updates on rising edge.
- reset  in  1  synchronous, active-low reset (0 = reset).
- start  in  1  one-cycle request to begin a frame; honoured only in IDLE or DONE.
- stall  in  1  downstream hold; when 1 all state and outputs freeze.
- PC  out  32  byte address of instruction to fetch; bits [1:0] always 0.
- pc_valid  out  1  PC is a real fetch this cycle.
- pixel_idx  out  PIX_W  index of pixel whose body is being fetched.
- pixel_start  out  1  PC is the first body instruction of pixel_idx.
- busy  out  1  in PROLOGUE or BODY.
- done  out  1  frame complete; held high in DONE.

Behaviour:
- States: IDLE, PROLOGUE, BODY, DONE (registered; Moore outputs).
- Reset (reset==0 at a clock edge): state=IDLE, PC=0, pc_valid=0, pixel_idx=0, pixel_start=0, busy=0, done=0. Applies mid-frame; no partial frame resumes.
- IDLE: pc_valid=0, PC=0. start=1 -> next cycle PROLOGUE, PC=0, pc_valid=1.
- PROLOGUE: each non-stalled cycle PC += 4. When PC == (PROLOGUE_LEN-1)*4 -> next BODY, PC=PROLOGUE_LEN*4, pixel_idx=0, pixel_start=1.
- BODY:
  - Body base B = PROLOGUE_LEN*4; body last address L = (PROLOGUE_LEN+N_BODY-1)*4.
  - PC < L: PC += 4, pixel_start=0.
  - PC == L and pixel_idx < NUM_PIXELS-1: PC wraps to B, pixel_idx += 1, pixel_start=1.
  - PC == L and pixel_idx == NUM_PIXELS-1: next DONE.
- N_BODY==1: every BODY cycle is both first and last; pixel_start=1 every cycle.
- DONE: pc_valid=0, busy=0, done=1, PC holds L, pixel_idx holds NUM_PIXELS-1. start=1 -> PROLOGUE with PC=0, pixel_idx=0, done=0.
- stall=1: no register changes, including state transitions. start is ignored during stall.
- start while busy: ignored; no restart, no error.
- Latency: start sampled at edge k -> first valid PC at cycle k+1. One PC per non-stalled cycle thereafter. Total valid fetches per frame = PROLOGUE_LEN + N_BODY*NUM_PIXELS.
- Arithmetic: PC is a 32-bit unsigned register; it never exceeds L, so no wrap. pixel_idx is a PIX_W-bit unsigned register that never exceeds NUM_PIXELS-1. Comparisons are against elaboration-time constants; no modulo or divide.

Decomposition:
- Shared package gpu_seq_pkg:
  - state enum seq_state_t {IDLE, PROLOGUE, BODY, DONE};
  - constants IMG_W=640, IMG_H=480, DEF_PROLOGUE_LEN=4, DEF_N_BODY=18, INSTR_BYTES=4.
- One natural sub-module: seq_wrap_counter, a parameterized count/wrap/hold counter with enable, clear and terminal-count flag. It is instantiated twice, once for the body offset and once for pixel_idx.

Test Plan (bench uses PROLOGUE_LEN=2, N_BODY=3, NUM_PIXELS=2 unless stated):
- Reset: hold reset=0 for 3 cycles with start=1 -> PC=0, pc_valid=0, done=0, busy=0; no fetch is issued.
- Full frame: start pulse -> PC sequence 0,4,8,12,16,8,12,16 with pc_valid=1 for 8 cycles. pixel_start=1 on both PC=8 cycles. pixel_idx is 0,0,0,0,0,1,1,1. Next cycle: done=1, pc_valid=0.
- Stall: assert stall for 3 cycles while PC=12, pixel_idx=0 -> PC, pixel_idx and state frozen; on release the next PC is 16.
- Mid-frame reset: assert reset=0 at PC=12, pixel_idx=1 -> next cycle IDLE, PC=0, pixel_idx=0. A new start yields PC=0 first.
- start while busy / restart from DONE: start at PC=4 -> ignored and the sequence is unchanged. start in DONE -> PC=0, done drops the next cycle.
- Defaults (PROLOGUE_LEN=4, N_BODY=18, NUM_PIXELS=307200): count valid fetches -> 5529604; last PC=84; final pixel_idx=307199.

Source files
------------

// File: rtl/gpu_seq_pkg.sv
// gpu_seq_pkg: shared state encoding and frame/instruction constants for the fetch sequencer
package gpu_seq_pkg;
  typedef enum logic [1:0] {IDLE, PROLOGUE, BODY, DONE} seq_state_t;
  localparam int IMG_W = 640;
  localparam int IMG_H = 480;
  localparam int DEF_PROLOGUE_LEN = 4;
  localparam int DEF_N_BODY = 18;
  localparam int INSTR_BYTES = 4;
endpackage

// File: rtl/seq_wrap_counter.sv
// seq_wrap_counter: counts 0..MAX with enable, wraps to 0 after MAX, clear overrides enable
module seq_wrap_counter #(
  parameter int W = 8,
  parameter int MAX = 255
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         en,
  input  logic         clr,
  output logic [W-1:0] count,
  output logic         tc
);
  assign tc = count == W'(MAX);
  always_ff @(posedge clk)
    if (rst || clr) count <= '0;
    else if (en) count <= tc ? '0 : count + 1'b1;
endmodule

// File: rtl/kernel_fetch_seq.sv
// kernel_fetch_seq: emits prologue PCs once, then replays the kernel body once per pixel
module kernel_fetch_seq
  import gpu_seq_pkg::*;
#(
  parameter int N_BODY = DEF_N_BODY,
  parameter int PROLOGUE_LEN = DEF_PROLOGUE_LEN,
  parameter int NUM_PIXELS = IMG_W * IMG_H,
  parameter int PIX_W = 19
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             stall,
  output logic [31:0]      PC,
  output logic             pc_valid,
  output logic [PIX_W-1:0] pixel_idx,
  output logic             pixel_start,
  output logic             busy,
  output logic             done
);
  localparam int OW = N_BODY > 1 ? $clog2(N_BODY) : 1;
  localparam logic [31:0] STEP = 32'(INSTR_BYTES);
  localparam logic [31:0] BASE = 32'(PROLOGUE_LEN * INSTR_BYTES);
  localparam logic [31:0] PRO_LAST = BASE - STEP;
  seq_state_t state, state_nx;
  logic [31:0] pc_nx;
  logic [OW-1:0] off;
  logic ps_nx, run, go, pro_end, off_tc, pix_tc;
  assign run = !stall;
  assign go = run && start && (state == IDLE || state == DONE);
  assign pro_end = state == PROLOGUE && PC == PRO_LAST;
  assign pc_valid = state == PROLOGUE || state == BODY;
  assign busy = pc_valid;
  assign done = state == DONE;
  // body PC is rebuilt from the offset counter, so the last fetch holds L on entry to DONE
  always_comb begin
    state_nx = state;
    pc_nx = PC;
    ps_nx = pixel_start;
    if (go) begin
      state_nx = PROLOGUE;
      pc_nx = '0;
      ps_nx = 1'b0;
    end else if (run && state == PROLOGUE) begin
      state_nx = pro_end ? BODY : PROLOGUE;
      pc_nx = PC + STEP;
      ps_nx = pro_end;
    end else if (run && state == BODY) begin
      state_nx = off_tc && pix_tc ? DONE : BODY;
      pc_nx = !off_tc ? BASE + (32'(off) + 32'd1) * STEP : pix_tc ? PC : BASE;
      ps_nx = off_tc && !pix_tc;
    end
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= IDLE;
      PC <= '0;
      pixel_start <= 1'b0;
    end else begin
      state <= state_nx;
      PC <= pc_nx;
      pixel_start <= ps_nx;
    end
  seq_wrap_counter #(.W(OW), .MAX(N_BODY - 1)) u_off (
    .clk(clk), .rst(!reset), .en(run && state == BODY), .clr(run && state == PROLOGUE),
    .count(off), .tc(off_tc)
  );
  seq_wrap_counter #(.W(PIX_W), .MAX(NUM_PIXELS - 1)) u_pix (
    .clk(clk), .rst(!reset), .en(run && state == BODY && off_tc && !pix_tc), .clr(go),
    .count(pixel_idx), .tc(pix_tc)
  );
endmodule

// File: tb/tb_kernel_fetch_seq.sv
// tb_kernel_fetch_seq: scoreboard bench on a small frame plus a fetch-count run on a larger kernel
module tb_kernel_fetch_seq;
  logic clk = 0, reset = 0, start = 1, stall = 0, start2 = 0;
  logic [31:0] PC, PC2;
  logic pc_valid, pixel_start, busy, done;
  logic [0:0] pixel_idx;
  logic pc_valid2, pixel_start2, busy2, done2;
  logic [5:0] pixel_idx2;
  typedef struct packed {logic [31:0] pc; logic idx; logic ps;} exp_t;
  exp_t q[$];
  int tests = 0, fails = 0, fetch2 = 0;
  logic [31:0] last_pc2 = '0;

  always #5 clk = ~clk;

  kernel_fetch_seq #(.N_BODY(3), .PROLOGUE_LEN(2), .NUM_PIXELS(2), .PIX_W(1)) dut (
    .clk(clk), .reset(reset), .start(start), .stall(stall), .PC(PC), .pc_valid(pc_valid),
    .pixel_idx(pixel_idx), .pixel_start(pixel_start), .busy(busy), .done(done)
  );
  kernel_fetch_seq #(.N_BODY(18), .PROLOGUE_LEN(4), .NUM_PIXELS(50), .PIX_W(6)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .stall(1'b0), .PC(PC2), .pc_valid(pc_valid2),
    .pixel_idx(pixel_idx2), .pixel_start(pixel_start2), .busy(busy2), .done(done2)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [31:0] pc, input logic idx, input logic ps);
    q.push_back('{pc: pc, idx: idx, ps: ps});
  endtask

  task automatic push_frame(input int n);
    exp_t f[8];
    f = '{'{0, 0, 0}, '{4, 0, 0}, '{8, 0, 1}, '{12, 0, 0}, '{16, 0, 0}, '{8, 1, 1}, '{12, 1, 0}, '{16, 1, 0}};
    for (int i = 0; i < n; i++) push(f[i].pc, f[i].idx, f[i].ps);
  endtask

  // a fetch is consumed on the edge following a cycle where it is valid, unstalled and not reset
  always @(negedge clk)
    if (reset && !stall && pc_valid) begin
      if (q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_fetch: got PC %0d expected no fetch", PC);
      end else begin
        exp_t e;
        e = q.pop_front();
        chk("fetch_pc", PC, e.pc);
        chk("fetch_idx", 32'(pixel_idx), 32'(e.idx));
        chk("fetch_pstart", 32'(pixel_start), 32'(e.ps));
      end
    end

  always @(negedge clk)
    if (reset && pc_valid2) begin
      fetch2++;
      last_pc2 = PC2;
    end

  initial begin
    step(3);
    chk("rst_pc", PC, 0);
    chk("rst_valid", 32'(pc_valid), 0);
    chk("rst_done", 32'(done), 0);
    chk("rst_busy", 32'(busy), 0);
    reset = 1;
    start = 0;
    step(1);
    push_frame(8);
    start = 1;
    step(1);
    start = 0;
    chk("first_busy", 32'(busy), 1);
    step(8);
    chk("end_done", 32'(done), 1);
    chk("end_valid", 32'(pc_valid), 0);
    chk("end_busy", 32'(busy), 0);
    chk("end_pc", PC, 16);
    chk("end_idx", 32'(pixel_idx), 1);
    push_frame(8);
    start = 1;
    step(1);
    chk("restart_done_drop", 32'(done), 0);
    chk("restart_pc", PC, 0);
    start = 0;
    step(1);
    start = 1;
    step(1);
    start = 0;
    chk("busy_start_pc", PC, 8);
    step(6);
    chk("busy_start_done", 32'(done), 1);
    push_frame(8);
    start = 1;
    step(1);
    start = 0;
    step(3);
    stall = 1;
    start = 1;
    step(3);
    start = 0;
    chk("stall_pc", PC, 12);
    chk("stall_idx", 32'(pixel_idx), 0);
    chk("stall_valid", 32'(pc_valid), 1);
    stall = 0;
    step(1);
    chk("unstall_pc", PC, 16);
    step(4);
    chk("stall_frame_done", 32'(done), 1);
    push_frame(6);
    start = 1;
    step(1);
    start = 0;
    step(6);
    chk("pre_reset_pc", PC, 12);
    chk("pre_reset_idx", 32'(pixel_idx), 1);
    reset = 0;
    step(1);
    reset = 1;
    chk("mid_rst_pc", PC, 0);
    chk("mid_rst_idx", 32'(pixel_idx), 0);
    chk("mid_rst_valid", 32'(pc_valid), 0);
    chk("mid_rst_done", 32'(done), 0);
    push_frame(8);
    start = 1;
    step(1);
    start = 0;
    step(8);
    chk("post_rst_done", 32'(done), 1);
    start2 = 1;
    step(1);
    start2 = 0;
    for (int n = 0; n < 3000 && !done2; n++) step(1);
    chk("big_done", 32'(done2), 1);
    chk("big_fetches", 32'(fetch2), 904);
    chk("big_last_pc", last_pc2, 84);
    chk("big_hold_pc", PC2, 84);
    chk("big_idx", 32'(pixel_idx2), 49);
    chk("scoreboard_drain", 32'(q.size()), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
